// File: rtl/clk_ena_prescaler_if.sv
// Control/strobe bundle between the timer control block and clk_ena_prescaler.
// Master drives run/clr/src_sel/div_sel/ext_in; slave returns clk_ena/sel_act.
interface clk_ena_prescaler_if #(
  parameter int SEL_W = 4
);
  logic             run;
  logic             clr;
  logic [1:0]       src_sel;
  logic [SEL_W-1:0] div_sel;
  logic             ext_in;
  logic             clk_ena;
  logic [SEL_W-1:0] sel_act;

  modport master (
    output run,
    output clr,
    output src_sel,
    output div_sel,
    output ext_in,
    input  clk_ena,
    input  sel_act
  );

  modport slave (
    input  run,
    input  clr,
    input  src_sel,
    input  div_sel,
    input  ext_in,
    output clk_ena,
    output sel_act
  );
endinterface

// File: rtl/clk_ena_prescaler.sv
// One-clk clk_ena strobe from a power-of-two prescaler or a synchronised ext edge.
// PRESCALER_SEL_SYNC_EN: div_sel only taken on period boundaries / clr / run=0.
module clk_ena_prescaler #(
  parameter int DIV_W = 8,
  parameter int SEL_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  clk_ena_prescaler_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_MAX =
    SEL_W'(DIV_W);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] mask;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_sat;
  logic [1:0]       src_q;
  logic             ena_q;
  logic             ena_d;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             is_int;
  logic             hit;
  logic             ext_hit;
  logic             sel_load;

  assign bus.clk_ena = ena_q;
  assign bus.sel_act = sel_q;

  assign sel_sat =
    (32'(bus.div_sel) > 32'(DIV_W))
      ? SEL_MAX : bus.div_sel;

  assign is_int =
    (bus.src_sel == 2'b00) ||
    (bus.src_sel == 2'b11);

  // Low sel_q bits set; zero-width mask makes s=0 hit every cycle.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DIV_W; i++) begin
      mask[i] = (32'(i) < 32'(sel_q));
    end
  end

  assign hit = ((cnt & mask) == mask);

  assign ext_hit =
    (bus.src_sel == 2'b01) ? (s2 & ~s3)
                           : (~s2 & s3);

  always_comb begin
    cnt_d = cnt;
    ena_d = 1'b0;
    unique case (1'b1)
      !is_int: begin
        cnt_d = '0;
        ena_d = bus.run & ~bus.clr & ext_hit;
      end
      is_int && bus.clr: begin
        cnt_d = '0;
      end
      is_int && !bus.clr && !bus.run: begin
        cnt_d = cnt;
      end
      default: begin
        cnt_d = cnt + DIV_W'(1);
        ena_d = hit;
      end
    endcase
`ifdef PRESCALER_SEL_SYNC_EN
    // New ratio starts a fresh period on the strobe edge.
    if (is_int && bus.run && !bus.clr &&
        hit && (sel_sat != sel_q)) begin
      cnt_d = '0;
    end
`endif
    if (bus.src_sel != src_q) begin
      cnt_d = '0;
    end
  end

`ifdef PRESCALER_SEL_SYNC_EN
  assign sel_load =
    bus.clr | ~bus.run | ena_d;
`else
  assign sel_load = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      ena_q <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      sel_q <= '0;
      src_q <= 2'b00;
    end else begin
      cnt   <= cnt_d;
      ena_q <= ena_d;
      s1    <= bus.ext_in;
      s2    <= s1;
      s3    <= s2;
      src_q <= bus.src_sel;
      if (sel_load) begin
        sel_q <= sel_sat;
      end
    end
  end

endmodule
